// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: load/store arbitration, one-line read buffer, word select.
// Optional performance counters are built when DMEM_PERF_CNT_EN is defined.
module dmem_access_ctrl #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ld_req,
    input  logic [31:0]        ld_addr,
    input  logic [TAG_W-1:0]   ld_tag,
    output logic               ld_ready,
    output logic               ld_valid,
    output logic [31:0]        ld_data,
    output logic [TAG_W-1:0]   ld_tag_out,
    input  logic               st_req,
    input  logic [31:0]        st_addr,
    input  logic [31:0]        st_data,
    output logic               st_ready,
    output logic               st_done,
    output logic [31:0]        mem_read_address,
    input  logic               mem_read_enable,
    input  logic [511:0]       mem_data_out,
    output logic [31:0]        mem_write_address,
    output logic               mem_write_request,
    output logic [31:0]        mem_write_data,
    input  logic               mem_write_done,
    output logic [CNT_W-1:0]   perf_hit,
    output logic [CNT_W-1:0]   perf_miss,
    output logic [CNT_W-1:0]   perf_store
);

    localparam int unsigned LINE_W  = 26;
    localparam int unsigned WORD_W  = 4;
    localparam int unsigned LBITS_W = 512;

    typedef enum logic [2:0] {
        IDLE,
        RD_BUMP,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              next_state;

    logic                last_grant_st;
    logic                buf_valid;
    logic [LINE_W-1:0]   buf_line;
    logic [LBITS_W-1:0]  line_buf;
    logic [LINE_W-1:0]   req_line;
    logic [WORD_W-1:0]   req_word;
    logic [TAG_W-1:0]    req_tag;
    logic                wr_armed;

    logic [LINE_W-1:0]   ld_line_c;
    logic                ld_grant_c;
    logic                st_grant_c;
    logic                ld_acc_c;
    logic                st_acc_c;
    logic                ld_hit_c;
    logic                ld_bump_c;
    logic                rd_fill_c;
    logic                wr_cmpl_c;
    logic                unused_c;

    function automatic logic [31:0] word_sel(input logic [LBITS_W-1:0] line,
                                             input logic [WORD_W-1:0]  word);
        return line[{word, 5'b0} +: 32];
    endfunction

    assign ld_line_c  = ld_addr[31:6];
    assign unused_c   = ^ld_addr[1:0];

    // Round-robin between the ports; a lone requester always wins.
    assign ld_grant_c = ld_req & (~st_req | last_grant_st);
    assign st_grant_c = st_req & (~ld_req | ~last_grant_st);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        st_ready   = 1'b0;
        ld_acc_c   = 1'b0;
        st_acc_c   = 1'b0;
        ld_hit_c   = 1'b0;
        ld_bump_c  = 1'b0;
        rd_fill_c  = 1'b0;
        wr_cmpl_c  = 1'b0;
        case (state)
            IDLE: begin
                // Holding ready low until the memory reports idle drains writes left over from a reset.
                ld_ready = mem_write_done & ld_grant_c;
                st_ready = mem_write_done & st_grant_c;
                ld_acc_c = ld_req & ld_ready;
                st_acc_c = st_req & st_ready;
                if (ld_acc_c) begin
                    if (buf_valid && (buf_line == ld_line_c)) begin
                        ld_hit_c   = 1'b1;
                        next_state = RESP;
                    end else if (ld_line_c == mem_read_address[31:6]) begin
                        ld_bump_c  = 1'b1;
                        next_state = RD_BUMP;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end else if (st_acc_c) begin
                    next_state = WR_ISSUE;
                end
            end
            RD_BUMP:  next_state = RD_ISSUE;
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT: begin
                if (mem_read_enable) begin
                    rd_fill_c  = 1'b1;
                    next_state = RESP;
                end
            end
            WR_ISSUE: next_state = WR_WAIT;
            WR_WAIT: begin
                if (wr_armed && mem_write_done) begin
                    wr_cmpl_c  = 1'b1;
                    next_state = IDLE;
                end
            end
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Control and memory-interface registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_valid          <= 1'b0;
            ld_data           <= 32'h0;
            ld_tag_out        <= '0;
            st_done           <= 1'b0;
            mem_read_address  <= 32'h0;
            mem_write_address <= 32'h0;
            mem_write_request <= 1'b0;
            mem_write_data    <= 32'h0;
            buf_valid         <= 1'b0;
            last_grant_st     <= 1'b1;
            wr_armed          <= 1'b0;
        end else begin
            ld_valid          <= (next_state == RESP);
            st_done           <= wr_cmpl_c;
            mem_write_request <= (next_state == WR_ISSUE);
            wr_armed          <= (state == WR_WAIT);
            if (ld_acc_c) begin
                last_grant_st <= 1'b0;
            end
            if (st_acc_c) begin
                last_grant_st     <= 1'b1;
                mem_write_address <= st_addr;
                mem_write_data    <= st_data;
            end
            if (ld_hit_c) begin
                ld_data    <= word_sel(line_buf, ld_addr[5:2]);
                ld_tag_out <= ld_tag;
            end
            // A neighbouring line is driven first when the wanted line is already on the bus.
            if (ld_acc_c && !ld_hit_c) begin
                mem_read_address <= {(ld_bump_c ? (ld_line_c ^ LINE_W'(1)) : ld_line_c), 6'b0};
            end
            if (state == RD_BUMP) begin
                mem_read_address <= {req_line, 6'b0};
            end
            if (rd_fill_c) begin
                buf_valid  <= 1'b1;
                ld_data    <= word_sel(mem_data_out, req_word);
                ld_tag_out <= req_tag;
            end
        end
    end

    // Line buffer and captured load request; contents are qualified by buf_valid.
    always_ff @(posedge clock) begin
        if (ld_acc_c) begin
            req_line <= ld_line_c;
            req_word <= ld_addr[5:2];
            req_tag  <= ld_tag;
        end
        if (rd_fill_c) begin
            line_buf <= mem_data_out;
            buf_line <= req_line;
        end
        if (wr_cmpl_c && buf_valid && (buf_line == mem_write_address[31:6])) begin
            line_buf[{mem_write_address[5:2], 5'b0} +: 32] <= mem_write_data;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_hit   <= '0;
            perf_miss  <= '0;
            perf_store <= '0;
        end else begin
            if (ld_hit_c) begin
                perf_hit <= perf_hit + CNT_W'(1);
            end
            if (ld_acc_c && !ld_hit_c) begin
                perf_miss <= perf_miss + CNT_W'(1);
            end
            if (wr_cmpl_c) begin
                perf_store <= perf_store + CNT_W'(1);
            end
        end
    end
`else
    assign perf_hit   = '0;
    assign perf_miss  = '0;
    assign perf_store = '0;
`endif

    ap_ready_excl: assert property (@(posedge clock) disable iff (reset)
        !(ld_ready && st_ready));
    ap_wr_pulse: assert property (@(posedge clock) disable iff (reset)
        mem_write_request |=> !mem_write_request);
    ap_ld_pulse: assert property (@(posedge clock) disable iff (reset)
        ld_valid |=> !ld_valid);

endmodule
